// File: rtl/program_loader.sv
// program_loader: boot-time writer for the nRisc instruction memory.
// Takes a framed byte stream (MAGIC, length, payload, XOR checksum).
// Writes the payload from BASE_ADDR upward through the memory write port.
// Holds the processor in reset until a frame has loaded and verified.
module program_loader #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h00,
  parameter logic [DATA_WIDTH-1:0] MAGIC      = 8'hA5
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  InValid,
  input  logic [DATA_WIDTH-1:0] InData,
  output logic                  InReady,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemData,
  output logic                  CpuResetN,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN,
    LOAD,
    CHK,
    DONE,
    ERROR
  } stateT;

  stateT                 state;
  stateT                 nextState;
  logic [DATA_WIDTH-1:0] lenReg;     // payload length, 0 encodes 2^DATA_WIDTH
  logic [DATA_WIDTH-1:0] count;      // payload bytes written so far
  logic [DATA_WIDTH-1:0] lastIndex;  // index of the final payload byte
  logic [ADDR_WIDTH-1:0] addrPtr;    // address for the next payload byte
  logic [DATA_WIDTH-1:0] checksum;   // running XOR of the payload
  logic                  accept;
  logic                  busyNext;

  // InReady is a registered copy of "state is HDR..CHK", so it agrees with state.
  assign accept = InValid && InReady;

  // The subtraction wraps, so a length of 0 makes the last index all ones.
  assign lastIndex = lenReg - DATA_WIDTH'(1);

  // Next-state logic for the frame parser.
  always_comb begin
    // NOTE: defaulting nextState before the case keeps every path assigned and prevents latch inference.
    nextState = state;
    unique case (state)
      IDLE:  if (Start) nextState = HDR;
      HDR:   if (accept && InData == MAGIC) nextState = LEN;
      LEN:   if (accept) nextState = LOAD;
      LOAD:  if (accept && count == lastIndex) nextState = CHK;
      CHK:   if (accept) nextState = (InData == checksum) ? DONE : ERROR;
      DONE:  if (Start) nextState = HDR;
      ERROR: if (Start) nextState = HDR;
      default: nextState = IDLE;
    endcase
  end

  assign busyNext = (nextState == HDR) || (nextState == LEN) ||
                    (nextState == LOAD) || (nextState == CHK);

  // State register, registered status outputs, payload counters and write port.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      InReady   <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
      CpuResetN <= 1'b0;
      MemWrite  <= 1'b0;
      MemAddr   <= '0;
      MemData   <= '0;
      lenReg    <= '0;
      count     <= '0;
      addrPtr   <= '0;
      checksum  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values, avoiding order-dependent races.
      state     <= nextState;
      InReady   <= busyNext;
      Busy      <= busyNext;
      Done      <= (nextState == DONE);
      Error     <= (nextState == ERROR);
      CpuResetN <= (nextState == DONE);
      MemWrite  <= 1'b0;

      // Length byte: latch it and rewind the payload bookkeeping.
      if (state == LEN && accept) begin
        lenReg   <= InData;
        count    <= '0;
        addrPtr  <= BASE_ADDR;
        checksum <= '0;
      end

      // Payload byte: strobe it into memory the following cycle.
      if (state == LOAD && accept) begin
        MemWrite <= 1'b1;
        MemAddr  <= addrPtr;
        MemData  <= InData;
        addrPtr  <= addrPtr + ADDR_WIDTH'(1);
        count    <= count + DATA_WIDTH'(1);
        checksum <= checksum ^ InData;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader. Two instances share one stream: one based at
// 8'h00 and one at 8'hF0. Expected memory writes go into per-instance queues
// as payload bytes are accepted. A negedge monitor pops and compares them.
module tb_program_loader;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Start;
  logic       InValid;
  logic [7:0] InData;

  logic       InReady,   MemWrite,   CpuResetN,   Busy,   Done,   Error;
  logic [7:0] MemAddr,   MemData;
  logic       InReadyHi, MemWriteHi, CpuResetNHi, BusyHi, DoneHi, ErrorHi;
  logic [7:0] MemAddrHi, MemDataHi;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] cycle;
  } wrT;

  wrT         expLo[$];
  wrT         expHi[$];
  logic [7:0] frame[$];
  logic [31:0] cycleCnt = 0;
  int         checks   = 0;
  int         failures = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cycleCnt <= cycleCnt + 1;

  program_loader #(.BASE_ADDR(8'h00)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .InValid(InValid),
    .InData(InData), .InReady(InReady), .MemWrite(MemWrite),
    .MemAddr(MemAddr), .MemData(MemData), .CpuResetN(CpuResetN),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  program_loader #(.BASE_ADDR(8'hF0)) dutHi (
    .Clock(Clock), .Reset(Reset), .Start(Start), .InValid(InValid),
    .InData(InData), .InReady(InReadyHi), .MemWrite(MemWriteHi),
    .MemAddr(MemAddrHi), .MemData(MemDataHi), .CpuResetN(CpuResetNHi),
    .Busy(BusyHi), .Done(DoneHi), .Error(ErrorHi)
  );

  // Monitor for the base-0 instance: every strobe must match the queue head.
  always @(negedge Clock) begin
    wrT e;
    if (MemWrite !== 1'b0) begin
      checks++;
      if (expLo.size() == 0) begin
        failures++;
        $display("FAIL lo_write: got unexpected write addr=%h data=%h at cycle %0d, required none",
                 MemAddr, MemData, cycleCnt);
      end else begin
        e = expLo.pop_front();
        if ({MemWrite, MemAddr, MemData, cycleCnt} !== {1'b1, e.addr, e.data, e.cycle}) begin
          failures++;
          $display("FAIL lo_write: got addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d",
                   MemAddr, MemData, cycleCnt, e.addr, e.data, e.cycle);
        end
      end
    end
  end

  // Monitor for the base-F0 instance.
  always @(negedge Clock) begin
    wrT e;
    if (MemWriteHi !== 1'b0) begin
      checks++;
      if (expHi.size() == 0) begin
        failures++;
        $display("FAIL hi_write: got unexpected write addr=%h data=%h at cycle %0d, required none",
                 MemAddrHi, MemDataHi, cycleCnt);
      end else begin
        e = expHi.pop_front();
        if ({MemWriteHi, MemAddrHi, MemDataHi, cycleCnt} !== {1'b1, e.addr, e.data, e.cycle}) begin
          failures++;
          $display("FAIL hi_write: got addr=%h data=%h cycle=%0d, required addr=%h data=%h cycle=%0d",
                   MemAddrHi, MemDataHi, cycleCnt, e.addr, e.data, e.cycle);
        end
      end
    end
  end

  // Pulse Start for one cycle and confirm the loader became busy.
  task automatic start_pulse(input string name);
    Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    checks++;
    if ({Busy, InReady, BusyHi} !== 3'b111) begin
      failures++;
      $display("FAIL %s_start: got Busy/InReady/BusyHi=%b%b%b, required 111", name, Busy, InReady, BusyHi);
    end
  endtask

  // Stream the bytes of 'frame'. Bytes payStart..payStart+payCount-1 are payload.
  // Optional idle gaps toggle InValid; Start is raised with byte startAt.
  task automatic send_frame(input string name, input int payStart, input int payCount,
                            input bit gaps, input int startAt);
    bit accepted;
    int waited;
    int j;
    for (int i = 0; i < frame.size(); i++) begin
      if (gaps) begin
        InValid = 1'b0;
        @(posedge Clock); #1;
      end
      InValid  = 1'b1;
      InData   = frame[i];
      Start    = (i == startAt);
      accepted = 1'b0;
      waited   = 0;
      while (!accepted && waited < 20) begin
        @(negedge Clock);
        accepted = InReady;
        @(posedge Clock); #1;
        Start = 1'b0;
        waited++;
      end
      if (!accepted) begin
        checks++;
        failures++;
        $display("FAIL %s_accept: byte %0d got InReady never high, required acceptance", name, i);
        InValid = 1'b0;
        return;
      end
      if (i >= payStart && i < payStart + payCount) begin
        j = i - payStart;
        expLo.push_back('{addr: 8'(j), data: frame[i], cycle: cycleCnt});
        expHi.push_back('{addr: 8'h F0 + 8'(j), data: frame[i], cycle: cycleCnt});
      end
      if (i != frame.size() - 1) begin
        checks++;
        if ({CpuResetN, Busy, Done} !== 3'b010) begin
          failures++;
          $display("FAIL %s_midframe: byte %0d got CpuResetN/Busy/Done=%b%b%b, required 010",
                   name, i, CpuResetN, Busy, Done);
        end
      end
    end
    InValid = 1'b0;
  endtask

  // Check the final status levels of both instances.
  task automatic check_result(input string name, input bit expDone);
    logic [3:0] want;
    want = {expDone, ~expDone, expDone, 1'b0};
    checks++;
    if ({Done, Error, CpuResetN, Busy} !== want ||
        {DoneHi, ErrorHi, CpuResetNHi, BusyHi} !== want) begin
      failures++;
      $display("FAIL %s_result: got Done/Error/CpuResetN/Busy=%b%b%b%b hi=%b%b%b%b, required %b",
               name, Done, Error, CpuResetN, Busy, DoneHi, ErrorHi, CpuResetNHi, BusyHi, want);
    end
  endtask

  // Give outstanding writes time to appear, then require empty queues.
  task automatic drain(input string name);
    repeat (3) @(posedge Clock);
    #1;
    checks++;
    if (expLo.size() != 0 || expHi.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d/%0d writes outstanding, required 0/0",
               name, expLo.size(), expHi.size());
    end
    expLo.delete();
    expHi.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b0; Start = 1'b0; InValid = 1'b0; InData = 8'h00;
    #1;
    checks++;
    if ({InReady, MemWrite, MemAddr, MemData, CpuResetN, Busy, Done, Error} !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs: got nonzero outputs, required all zero");
    end
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_abort();
    start_pulse("abort");
    frame = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_frame("abort", 2, 2, 1'b0, -1);
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    checks++;
    if ({InReady, MemWrite, MemAddr, MemData, CpuResetN, Busy, Done, Error} !== 22'd0 ||
        {InReadyHi, MemWriteHi, MemAddrHi, MemDataHi, CpuResetNHi, BusyHi, DoneHi, ErrorHi} !== 22'd0) begin
      failures++;
      $display("FAIL abort_outputs: got MemWrite=%b MemAddr=%h Busy=%b, required all zero",
               MemWrite, MemAddr, Busy);
    end
    @(posedge Clock); #1;
    Reset   = 1'b1;
    InValid = 1'b1;
    InData  = 8'hA5;
    repeat (10) @(posedge Clock);
    #1;
    checks++;
    if ({Busy, InReady, Done, Error} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_idle: got Busy/InReady/Done/Error=%b%b%b%b, required 0000",
               Busy, InReady, Done, Error);
    end
    InValid = 1'b0;
    drain("abort");
  endtask

  task automatic test_load();
    start_pulse("load");
    frame = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
    send_frame("load", 2, 3, 1'b0, -1);
    check_result("load", 1'b1);
    drain("load");
  endtask

  task automatic test_bad_checksum();
    start_pulse("badsum");
    frame = '{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'h00};
    send_frame("badsum", 2, 2, 1'b0, -1);
    check_result("badsum", 1'b0);
    drain("badsum");
    start_pulse("reload");
    frame = '{8'hA5, 8'h02, 8'h0F, 8'hF0, 8'hFF};
    send_frame("reload", 2, 2, 1'b0, -1);
    check_result("reload", 1'b1);
    drain("reload");
  endtask

  task automatic test_resync();
    start_pulse("resync");
    frame = '{8'h3C, 8'h00, 8'hA5, 8'h01, 8'h5A, 8'h5A};
    send_frame("resync", 4, 1, 1'b0, -1);
    check_result("resync", 1'b1);
    drain("resync");
  endtask

  task automatic test_full_256();
    start_pulse("full");
    frame = '{8'hA5, 8'h00};
    for (int b = 0; b < 256; b++) frame.push_back(8'(b));
    frame.push_back(8'h00);
    send_frame("full", 2, 256, 1'b0, -1);
    check_result("full", 1'b1);
    drain("full");
  endtask

  task automatic test_back_to_back_gaps();
    start_pulse("gaps");
    frame = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
    send_frame("gaps", 2, 3, 1'b1, 3);
    check_result("gaps", 1'b1);
    drain("gaps");
  endtask

  initial begin
    test_reset();
    test_abort();
    test_load();
    test_bad_checksum();
    test_resync();
    test_full_256();
    test_back_to_back_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Backstop so a stuck run still terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
